// File: rtl/load_read_unit.sv
// Load read unit: issues one word read per MEM-stage load and returns the extended result.
// Latency: 2 cycles for a zero-wait memory. Stall is held while a load is in flight.
module load_read_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [2:0]        ld_funct3_i,
    output logic              stall_o,
    output logic              ld_valid_o,
    output logic [31:0]       ld_data_o,
    output logic [1:0]        ld_err_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              ld_valid_q;
    logic [31:0]       ld_data_q;
    logic [1:0]        ld_err_q;

    logic              ld_ok;
    logic              accept;
    logic [31:0]       lane;
    logic [31:0]       ext_d;

    always_comb begin
        ld_ok = 1'b0;
        case (ld_funct3_i)
            3'b000, 3'b100: ld_ok = 1'b1;
            3'b001, 3'b101: ld_ok = ~ld_addr_i[0];
            3'b010:         ld_ok = (ld_addr_i[1:0] == 2'b00);
            default:        ld_ok = 1'b0;
        endcase
    end

    assign accept  = (state_q == IDLE) & ld_req_i & ld_ok;
    assign stall_o = (state_q == REQ) | accept;

    assign lane = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ext_d = lane;
        case (f3_q)
            3'b000:  ext_d = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ext_d = {24'd0, lane[7:0]};
            3'b001:  ext_d = {{16{lane[15]}}, lane[15:0]};
            3'b101:  ext_d = {16'd0, lane[15:0]};
            default: ext_d = lane;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
            ld_err_q   <= '0;
        end else begin
            ld_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A late ack after a timeout lands here and is dropped.
                    if (ld_req_i) begin
                        if (ld_ok) begin
                            off_q      <= ld_addr_i[1:0];
                            f3_q       <= ld_funct3_i;
                            mem_addr_q <= {ld_addr_i[ADDR_W-1:2], 2'b00};
                            mem_req_q  <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= REQ;
                        end else begin
                            ld_valid_q <= 1'b1;
                            ld_err_q   <= 2'b01;
                            ld_data_q  <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        mem_req_q  <= 1'b0;
                        ld_valid_q <= 1'b1;
                        ld_err_q   <= 2'b00;
                        ld_data_q  <= ext_d;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                            mem_req_q  <= 1'b0;
                            ld_valid_q <= 1'b1;
                            ld_err_q   <= 2'b10;
                            ld_data_q  <= '0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign ld_valid_o = ld_valid_q;
    assign ld_data_o  = ld_data_q;
    assign ld_err_o   = ld_err_q;

endmodule

// File: tb/tb_load_read_unit.sv
// Directed bench for load_read_unit with TIMEOUT=4.
module tb_load_read_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ld_req_i;
    logic [31:0] ld_addr_i;
    logic [2:0]  ld_funct3_i;
    logic        stall_o;
    logic        ld_valid_o;
    logic [31:0] ld_data_o;
    logic [1:0]  ld_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    load_read_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ld_req_i    (ld_req_i),
        .ld_addr_i   (ld_addr_i),
        .ld_funct3_i (ld_funct3_i),
        .stall_o     (stall_o),
        .ld_valid_o  (ld_valid_o),
        .ld_data_o   (ld_data_o),
        .ld_err_o    (ld_err_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; ld_req_i = 1'b0; ld_addr_i = '0; ld_funct3_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        tick(); tick();
        n_cmp++; if (mem_req_o !== 1'b0)   begin n_bad++; $display("FAIL reset mem_req got %b want 0", mem_req_o); end
        n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset mem_addr got %h want 0", mem_addr_o); end
        n_cmp++; if (ld_valid_o !== 1'b0)  begin n_bad++; $display("FAIL reset ld_valid got %b want 0", ld_valid_o); end
        n_cmp++; if (ld_data_o !== 32'h0)  begin n_bad++; $display("FAIL reset ld_data got %h want 0", ld_data_o); end
        n_cmp++; if (ld_err_o !== 2'b00)   begin n_bad++; $display("FAIL reset ld_err got %b want 00", ld_err_o); end
        n_cmp++; if (stall_o !== 1'b0)     begin n_bad++; $display("FAIL reset stall got %b want 0", stall_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        ld_req_i = 1'b1; ld_addr_i = 32'h100; ld_funct3_i = 3'b010;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL lw stall_c0 got %b want 1", stall_o); end
        tick();
        ld_req_i = 1'b0;
        n_cmp++; if (mem_req_o !== 1'b1)    begin n_bad++; $display("FAIL lw mem_req_c1 got %b want 1", mem_req_o); end
        n_cmp++; if (mem_addr_o !== 32'h100) begin n_bad++; $display("FAIL lw mem_addr got %h want 100", mem_addr_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL lw stall_c1 got %b want 1", stall_o); end
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if (ld_valid_o !== 1'b1)       begin n_bad++; $display("FAIL lw ld_valid_c2 got %b want 1", ld_valid_o); end
        n_cmp++; if (ld_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw ld_data got %h want deadbeef", ld_data_o); end
        n_cmp++; if (ld_err_o !== 2'b00)        begin n_bad++; $display("FAIL lw ld_err got %b want 00", ld_err_o); end
        n_cmp++; if (mem_req_o !== 1'b0)        begin n_bad++; $display("FAIL lw mem_req_c2 got %b want 0", mem_req_o); end
        n_cmp++; if (stall_o !== 1'b0)          begin n_bad++; $display("FAIL lw stall_c2 got %b want 0", stall_o); end
        tick();
        n_cmp++; if (ld_valid_o !== 1'b0) begin n_bad++; $display("FAIL lw ld_valid_pulse got %b want 0", ld_valid_o); end
    endtask

    task automatic test_extend();
        logic [31:0] v_addr [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
        logic [2:0]  v_f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
        logic [31:0] v_exp  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AA,
                                    32'h000080AA, 32'h00000055, 32'h00005511};
        for (int i = 0; i < 6; i++) begin
            ld_req_i = 1'b1; ld_addr_i = v_addr[i]; ld_funct3_i = v_f3[i];
            tick();
            ld_req_i = 1'b0;
            n_cmp++; if (mem_addr_o !== 32'h100) begin n_bad++; $display("FAIL extend[%0d] mem_addr got %h want 100", i, mem_addr_o); end
            mem_ack_i = 1'b1; mem_rdata_i = 32'h80AA5511;
            tick();
            mem_ack_i = 1'b0;
            n_cmp++; if (ld_valid_o !== 1'b1)  begin n_bad++; $display("FAIL extend[%0d] ld_valid got %b want 1", i, ld_valid_o); end
            n_cmp++; if (ld_data_o !== v_exp[i]) begin n_bad++; $display("FAIL extend[%0d] ld_data got %h want %h", i, ld_data_o, v_exp[i]); end
            n_cmp++; if (ld_err_o !== 2'b00)   begin n_bad++; $display("FAIL extend[%0d] ld_err got %b want 00", i, ld_err_o); end
        end
        tick();
    endtask

    task automatic test_misaligned();
        logic [31:0] v_addr [6] = '{32'h102, 32'h101, 32'h103, 32'h100, 32'h100, 32'h100};
        logic [2:0]  v_f3   [6] = '{3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 6; i++) begin
            ld_req_i = 1'b1; ld_addr_i = v_addr[i]; ld_funct3_i = v_f3[i];
            #1;
            n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL misalign[%0d] stall got %b want 0", i, stall_o); end
            tick();
            ld_req_i = 1'b0;
            n_cmp++; if (ld_valid_o !== 1'b1) begin n_bad++; $display("FAIL misalign[%0d] ld_valid got %b want 1", i, ld_valid_o); end
            n_cmp++; if (ld_err_o !== 2'b01)  begin n_bad++; $display("FAIL misalign[%0d] ld_err got %b want 01", i, ld_err_o); end
            n_cmp++; if (ld_data_o !== 32'h0) begin n_bad++; $display("FAIL misalign[%0d] ld_data got %h want 0", i, ld_data_o); end
            n_cmp++; if (mem_req_o !== 1'b0)  begin n_bad++; $display("FAIL misalign[%0d] mem_req got %b want 0", i, mem_req_o); end
            tick();
            n_cmp++; if (ld_valid_o !== 1'b0) begin n_bad++; $display("FAIL misalign[%0d] ld_valid_pulse got %b want 0", i, ld_valid_o); end
        end
    endtask

    task automatic test_timeout();
        ld_req_i = 1'b1; ld_addr_i = 32'h200; ld_funct3_i = 3'b010;
        tick();
        ld_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_req_o !== 1'b1)  begin n_bad++; $display("FAIL timeout mem_req_c%0d got %b want 1", i + 1, mem_req_o); end
            n_cmp++; if (ld_valid_o !== 1'b0) begin n_bad++; $display("FAIL timeout ld_valid_c%0d got %b want 0", i + 1, ld_valid_o); end
            tick();
        end
        n_cmp++; if (mem_req_o !== 1'b0)  begin n_bad++; $display("FAIL timeout mem_req_end got %b want 0", mem_req_o); end
        n_cmp++; if (ld_valid_o !== 1'b1) begin n_bad++; $display("FAIL timeout ld_valid got %b want 1", ld_valid_o); end
        n_cmp++; if (ld_err_o !== 2'b10)  begin n_bad++; $display("FAIL timeout ld_err got %b want 10", ld_err_o); end
        n_cmp++; if (ld_data_o !== 32'h0) begin n_bad++; $display("FAIL timeout ld_data got %h want 0", ld_data_o); end
        n_cmp++; if (stall_o !== 1'b0)    begin n_bad++; $display("FAIL timeout stall got %b want 0", stall_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if (ld_valid_o !== 1'b0) begin n_bad++; $display("FAIL late_ack ld_valid got %b want 0", ld_valid_o); end
        n_cmp++; if (mem_req_o !== 1'b0)  begin n_bad++; $display("FAIL late_ack mem_req got %b want 0", mem_req_o); end
        n_cmp++; if (ld_err_o !== 2'b10)  begin n_bad++; $display("FAIL late_ack ld_err got %b want 10", ld_err_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        ld_req_i = 1'b1; ld_addr_i = 32'h300; ld_funct3_i = 3'b010;
        tick();
        ld_req_i = 1'b0; ld_addr_i = 32'hFFF0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (stall_o !== 1'b1)      begin n_bad++; $display("FAIL b2b stall_c%0d got %b want 1", i + 1, stall_o); end
            n_cmp++; if (mem_addr_o !== 32'h300) begin n_bad++; $display("FAIL b2b mem_addr_c%0d got %h want 300", i + 1, mem_addr_o); end
            n_cmp++; if (mem_req_o !== 1'b1)    begin n_bad++; $display("FAIL b2b mem_req_c%0d got %b want 1", i + 1, mem_req_o); end
            tick();
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL b2b stall_ack got %b want 1", stall_o); end
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if (ld_valid_o !== 1'b1)       begin n_bad++; $display("FAIL b2b ld_valid got %b want 1", ld_valid_o); end
        n_cmp++; if (ld_data_o !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b ld_data got %h want cafef00d", ld_data_o); end
        n_cmp++; if (ld_err_o !== 2'b00)        begin n_bad++; $display("FAIL b2b ld_err got %b want 00", ld_err_o); end
        ld_req_i = 1'b1; ld_addr_i = 32'h305; ld_funct3_i = 3'b100;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL b2b stall_second got %b want 1", stall_o); end
        tick();
        ld_req_i = 1'b0;
        n_cmp++; if (mem_req_o !== 1'b1)     begin n_bad++; $display("FAIL b2b mem_req_second got %b want 1", mem_req_o); end
        n_cmp++; if (mem_addr_o !== 32'h304) begin n_bad++; $display("FAIL b2b mem_addr_second got %h want 304", mem_addr_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000AB00;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if (ld_valid_o !== 1'b1)      begin n_bad++; $display("FAIL b2b ld_valid_second got %b want 1", ld_valid_o); end
        n_cmp++; if (ld_data_o !== 32'h000000AB) begin n_bad++; $display("FAIL b2b ld_data_second got %h want 000000ab", ld_data_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        ld_req_i = 1'b1; ld_addr_i = 32'h500; ld_funct3_i = 3'b010;
        tick();
        ld_req_i = 1'b0;
        tick();
        n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL rstmid mem_req_before got %b want 1", mem_req_o); end
        rst_i = 1'b1;
        #1;
        n_cmp++; if (mem_req_o !== 1'b0)  begin n_bad++; $display("FAIL rstmid mem_req got %b want 0", mem_req_o); end
        n_cmp++; if (stall_o !== 1'b0)    begin n_bad++; $display("FAIL rstmid stall got %b want 0", stall_o); end
        n_cmp++; if (ld_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid ld_valid got %b want 0", ld_valid_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
        tick();
        mem_ack_i = 1'b0;
        rst_i = 1'b0;
        tick();
        n_cmp++; if (ld_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid ld_valid_after got %b want 0", ld_valid_o); end
        n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rstmid mem_addr_after got %h want 0", mem_addr_o); end
        ld_req_i = 1'b1; ld_addr_i = 32'h600; ld_funct3_i = 3'b010;
        tick();
        ld_req_i = 1'b0;
        n_cmp++; if (mem_addr_o !== 32'h600) begin n_bad++; $display("FAIL rstmid mem_addr_post got %h want 600", mem_addr_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if (ld_valid_o !== 1'b1)       begin n_bad++; $display("FAIL rstmid ld_valid_post got %b want 1", ld_valid_o); end
        n_cmp++; if (ld_data_o !== 32'h12345678) begin n_bad++; $display("FAIL rstmid ld_data_post got %h want 12345678", ld_data_o); end
        n_cmp++; if (ld_err_o !== 2'b00)        begin n_bad++; $display("FAIL rstmid ld_err_post got %b want 00", ld_err_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_extend();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
